// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared types and sizing helpers for the adder BIST initiator
package adder_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic int sum_width(input int width);
      return width + 1;
   endfunction

   function automatic int vec_count(input int width);
      return 1 << (2 * width);
   endfunction

endpackage

// File: rtl/adder_bist_seq.sv
// rtl/adder_bist_seq.sv - operand index counter with per-vector latency wait counter
module adder_bist_seq
   import adder_bist_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int DUT_LATENCY = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               run,
   input  logic               halt,
   output logic [2*WIDTH-1:0] vec_idx,
   output logic               check_stb,
   output logic               last_vec
);

   localparam int VEC_W  = 2 * WIDTH;
   localparam int WAIT_W = (DUT_LATENCY > 0) ? $clog2(DUT_LATENCY + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DUT_LATENCY);
   localparam logic [VEC_W-1:0]  IDX_LAST  = VEC_W'(vec_count(WIDTH) - 1);

   logic [WAIT_W-1:0] wait_cnt;

   assign check_stb = run && (wait_cnt == WAIT_LAST);
   assign last_vec  = (vec_idx == IDX_LAST);

   // The index never wraps: it parks on the last (or halting) vector so operands hold in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_idx  <= '0;
         wait_cnt <= '0;
      end else if (load) begin
         vec_idx  <= '0;
         wait_cnt <= '0;
      end else if (run) begin
         if (check_stb) begin
            wait_cnt <= '0;
            if (!last_vec && !halt) begin
               vec_idx <= vec_idx + VEC_W'(1);
            end
         end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
      end
   end

endmodule

// File: rtl/adder_bist.sv
// rtl/adder_bist.sv - exhaustive adder self-test initiator; ADDER_BIST_STOP_ON_ERR_EN halts on first mismatch
module adder_bist
   import adder_bist_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int DUT_LATENCY = 0,
   parameter int ERR_CNT_W   = 9
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   output logic [WIDTH-1:0]     a_o,
   output logic [WIDTH-1:0]     b_o,
   input  logic [WIDTH:0]       s_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   output logic [WIDTH-1:0]     first_err_a_o,
   output logic [WIDTH-1:0]     first_err_b_o
);

   localparam int SUM_W = sum_width(WIDTH);

   state_t               state;
   state_t               state_nx;
   logic                 start_acc;
   logic                 run;
   logic                 check_stb;
   logic                 last_vec;
   logic                 mismatch;
   logic                 stop_err;
   logic [2*WIDTH-1:0]   vec_idx;
   logic [SUM_W-1:0]     exp_sum;

   // A start is only honoured outside a run, including on the final check cycle.
   assign start_acc = start_i && (state != DRIVE);
   assign run       = (state == DRIVE);

   adder_bist_seq #(
      .WIDTH       (WIDTH),
      .DUT_LATENCY (DUT_LATENCY)
   ) u_seq (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .load      (start_acc),
      .run       (run),
      .halt      (stop_err),
      .vec_idx   (vec_idx),
      .check_stb (check_stb),
      .last_vec  (last_vec)
   );

   assign a_o     = vec_idx[2*WIDTH-1:WIDTH];
   assign b_o     = vec_idx[WIDTH-1:0];
   assign exp_sum = {1'b0, a_o} + {1'b0, b_o};
   assign mismatch = check_stb && (s_i != exp_sum);

`ifdef ADDER_BIST_STOP_ON_ERR_EN
   assign stop_err = mismatch;
`else
   assign stop_err = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_i) state_nx = DRIVE;
         DRIVE:   if (check_stb && (last_vec || stop_err)) state_nx = DONE;
         DONE:    if (start_i) state_nx = DRIVE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy_o = 1'b0;
      done_o = 1'b0;
      pass_o = 1'b0;
      case (state)
         DRIVE:   busy_o = 1'b1;
         DONE: begin
            done_o = 1'b1;
            pass_o = (err_cnt_o == '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_o     <= '0;
         first_err_a_o <= '0;
         first_err_b_o <= '0;
      end else if (start_acc) begin
         err_cnt_o     <= '0;
         first_err_a_o <= '0;
         first_err_b_o <= '0;
      end else if (mismatch) begin
         if (err_cnt_o != '1) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
         end
         if (err_cnt_o == '0) begin
            first_err_a_o <= a_o;
            first_err_b_o <= b_o;
         end
      end
   end

endmodule
